spawn_scheduler: RTL and testbench

Arbitrates spawn requests from several obstacle spawners onto a fixed pool of on-screen object slots. Each grant allocates the lowest-numbered free slot, records a clamped y coordinate for it, and starts a cooldown that enforces a minimum gap between spawns. The block sits between the spawner instances and the object drawing/movement logic, which returns slots through `release` when an object leaves the screen.

---
 rtl/spawn_scheduler.sv | 157 +++++++++++++++
 tb/tb_spawn_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : spawn_scheduler
// Purpose : Round-robin spawn arbiter that assigns the lowest free object
//           slot, records a clamped y and enforces a tick-based cooldown.
//           The per-slot free input is named slot_release because "release"
//           is a reserved word. Define SPAWN_SCHED_STATS_EN to add the
//           spawn_count and drop_count statistics outputs.
// Revision: 1.0 - initial release
// ============================================================================
module spawn_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 8,
  parameter int Y_WIDTH   = 10,
  parameter int Y_MAX     = 440,
  parameter int GAP_TICKS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         tick,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*Y_WIDTH-1:0]   req_y,
  input  logic [NUM_SLOTS-1:0]         slot_release,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
  output logic [Y_WIDTH-1:0]           spawn_y,
  output logic [NUM_SLOTS-1:0]         slot_valid,
  output logic                         full,
  output logic                         cooling
`ifdef SPAWN_SCHED_STATS_EN
  ,
  output logic [15:0]                  spawn_count,
  output logic [15:0]                  drop_count
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [Y_WIDTH-1:0] c_Y_MAX = Y_WIDTH'(Y_MAX);
  localparam logic [7:0]         c_GAP   = 8'(GAP_TICKS);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COOLDOWN = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_win, w_idx;
  logic               w_win_found;
  logic [SLOT_W-1:0]  w_free;
  logic               w_go;
  logic [Y_WIDTH-1:0] w_req_y [NUM_REQ];
  logic [Y_WIDTH-1:0] w_y_sel;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack_y
    assign w_req_y[i] = req_y[i*Y_WIDTH +: Y_WIDTH];
  end

  assign full    = &slot_valid;
  assign cooling = (r_state == COOLDOWN);
  assign w_y_sel = w_req_y[w_win];

  // Search starts one past the last winner and wraps around.
  always_comb begin
    w_win_found = 1'b0;
    w_win       = '0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_win_found && req[w_idx]) begin
        w_win_found = 1'b1;
        w_win       = w_idx;
      end
    end
  end

  // Scanning downward leaves the lowest free index.
  always_comb begin
    w_free = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!slot_valid[s]) w_free = SLOT_W'(s);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_go        = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_win_found && !full) begin
          w_go        = 1'b1;
          w_state_nxt = COOLDOWN;
          w_cnt_nxt   = c_GAP;
        end
      end
      COOLDOWN: begin
        if (r_cnt == 8'd0) w_state_nxt = IDLE;
        else if (tick && enable) w_cnt_nxt = r_cnt - 8'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Release acts on the current map, so a slot being allocated is unaffected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= IDX_W'(NUM_REQ - 1);
      grant       <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_y     <= '0;
      slot_valid  <= '0;
    end else begin
      grant       <= '0;
      spawn_valid <= 1'b0;
      slot_valid  <= (slot_valid & ~slot_release) |
                     (w_go ? (NUM_SLOTS'(1) << w_free) : '0);
      if (w_go) begin
        grant       <= NUM_REQ'(1) << w_win;
        spawn_valid <= 1'b1;
        spawn_slot  <= w_free;
        spawn_y     <= (w_y_sel > c_Y_MAX) ? c_Y_MAX : w_y_sel;
        r_last      <= w_win;
      end
    end
  end

`ifdef SPAWN_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spawn_count <= '0;
      drop_count  <= '0;
    end else begin
      if (w_go && spawn_count != 16'hFFFF) spawn_count <= spawn_count + 16'd1;
      if (tick && enable && full && (|req) && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_spawn_scheduler
// Purpose : Directed self-checking bench for spawn_scheduler (default params).
// Revision: 1.0 - initial release
// ============================================================================
module tb_spawn_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, tick;
  logic [3:0]  req;
  logic [39:0] req_y;
  logic [7:0]  slot_release;
  logic [3:0]  grant;
  logic        spawn_valid;
  logic [2:0]  spawn_slot;
  logic [9:0]  spawn_y;
  logic [7:0]  slot_valid;
  logic        full, cooling;
`ifdef SPAWN_SCHED_STATS_EN
  logic [15:0] spawn_count, drop_count;
`endif

  int vectors = 0;
  int fails   = 0;

  spawn_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick),
    .req(req), .req_y(req_y), .slot_release(slot_release),
    .grant(grant), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot),
    .spawn_y(spawn_y), .slot_valid(slot_valid), .full(full), .cooling(cooling)
`ifdef SPAWN_SCHED_STATS_EN
    , .spawn_count(spawn_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int bound);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (spawn_valid !== 1'b1 && n < bound);
    vectors++;
    assert (spawn_valid === 1'b1)
    else begin
      fails++;
      $error("FAIL wait_grant: observed no spawn_valid in %0d cycles, expected a grant", bound);
    end
  endtask

  logic [3:0] exp_g [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int seen;

  initial begin
    reset = 1'b1; enable = 1'b0; tick = 1'b0; req = '0; req_y = '0; slot_release = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(spawn_valid), 32'h0);
    check("rst_slot", 32'(spawn_slot), 32'h0);
    check("rst_y", 32'(spawn_y), 32'h0);
    check("rst_slot_valid", 32'(slot_valid), 32'h0);
    check("rst_cooling", 32'(cooling), 32'h0);
    check("rst_full", 32'(full), 32'h0);

    // First grant, then cooldown of 3 ticks plus one cycle
    enable = 1'b1; req = 4'b0001; req_y[0 +: 10] = 10'd100;
    cyc();
    check("g1_grant", 32'(grant), 32'h1);
    check("g1_slot", 32'(spawn_slot), 32'd0);
    check("g1_y", 32'(spawn_y), 32'd100);
    check("g1_slot_valid", 32'(slot_valid), 32'h01);
    check("g1_cooling", 32'(cooling), 32'h1);
    cyc();
    check("g1_pulse_end", 32'(spawn_valid), 32'h0);
    check("g1_y_hold", 32'(spawn_y), 32'd100);
    tick = 1'b1;
    cyc(); cyc(); cyc();
    tick = 1'b0;
    check("cd_still_cooling", 32'(cooling), 32'h1);
    check("cd_no_dup", 32'(spawn_valid), 32'h0);
    cyc();
    check("cd_idle", 32'(cooling), 32'h0);
    check("cd_idle_nogrant", 32'(spawn_valid), 32'h0);
    cyc();
    check("g2_grant", 32'(grant), 32'h1);
    check("g2_slot", 32'(spawn_slot), 32'd1);
    check("g2_slot_valid", 32'(slot_valid), 32'h03);

    // Drain cooldown while freeing both slots
    req = '0; tick = 1'b1; slot_release = 8'h03;
    cyc();
    slot_release = '0;
    cyc(); cyc(); cyc();
    check("rel_both", 32'(slot_valid), 32'h00);

    // Round robin with all requesters, pointer last at 0
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(10);
      check($sformatf("rr%0d_grant", i), 32'(grant), 32'(exp_g[i]));
      check($sformatf("rr%0d_slot", i), 32'(spawn_slot), i);
    end
    req = '0;
    check("rr_slot_valid", 32'(slot_valid), 32'h1F);

    // Clamp and boundary y
    req = 4'b0100; req_y[20 +: 10] = 10'd900;
    wait_grant(10);
    check("clamp_grant", 32'(grant), 32'h4);
    check("clamp_slot", 32'(spawn_slot), 32'd5);
    check("clamp_y", 32'(spawn_y), 32'd440);
    req = 4'b1000; req_y[30 +: 10] = 10'd440;
    wait_grant(10);
    check("ymax_grant", 32'(grant), 32'h8);
    check("ymax_y", 32'(spawn_y), 32'd440);
    req = 4'b0001; req_y[0 +: 10] = 10'd7;
    wait_grant(10);
    check("fill_slot", 32'(spawn_slot), 32'd7);
    check("fill_y", 32'(spawn_y), 32'd7);
    check("fill_full", 32'(full), 32'h1);

    // Full: request stays pending
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (spawn_valid === 1'b1) seen++;
    end
    check("full_no_grant", 32'(seen), 32'd0);
    check("full_flag", 32'(full), 32'h1);
    slot_release = 8'h20;
    cyc();
    slot_release = '0;
    check("full_release", 32'(slot_valid), 32'hDF);
    check("full_cleared", 32'(full), 32'h0);
    wait_grant(5);
    check("reuse_grant", 32'(grant), 32'h1);
    check("reuse_slot", 32'(spawn_slot), 32'd5);

    // Freeze: counter at 2, disabled for 10 ticks, slot 2 freed meanwhile
    cyc();
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      slot_release = (i == 4) ? 8'h04 : 8'h00;
      cyc();
      if (spawn_valid === 1'b1) seen++;
    end
    slot_release = '0;
    check("frz_cooling", 32'(cooling), 32'h1);
    check("frz_no_grant", 32'(seen), 32'd0);
    check("frz_release", 32'(slot_valid), 32'hFB);
    enable = 1'b1;
    cyc();
    check("resume_c1", 32'(cooling), 32'h1);
    cyc();
    check("resume_c2", 32'(cooling), 32'h1);
    cyc();
    check("resume_idle", 32'(cooling), 32'h0);
    check("resume_nogrant", 32'(spawn_valid), 32'h0);
    cyc();
    check("resume_grant", 32'(grant), 32'h1);
    check("resume_slot", 32'(spawn_slot), 32'd2);
    cyc();
    check("resume_pulse_end", 32'(grant), 32'h0);

    // Asynchronous reset mid-cooldown
    #2 reset = 1'b1;
    #1;
    check("arst_slot_valid", 32'(slot_valid), 32'h00);
    check("arst_cooling", 32'(cooling), 32'h0);
    check("arst_y", 32'(spawn_y), 32'h0);
    cyc();
    reset = 1'b0;
    req = 4'b1111;
    wait_grant(5);
    check("arst_rr_grant", 32'(grant), 32'h1);
    check("arst_rr_slot", 32'(spawn_slot), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
